// File: rtl/toast_pkg.sv
// Shared encodings for the toast datapath: ALU op constants plus the
// operation codes and sequencer states of the PC/stack unit.
package toast_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_PASS = 4'h7;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_STEP = 3'd1,
    OP_JUMP = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_PUSH = 3'd5,
    OP_POP  = 3'd6
  } op_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_stack_unit.sv
// Program counter and descending hardware stack with a single-port memory
// interface; PUSH/CALL take one write cycle, POP/RET wait for read data.
//
// Handshake: an operation is accepted on a rising edge where op_valid and
// op_ready are both high; op_ready is high only while idle, so op_code,
// op_target and op_data need only be valid in the accept cycle.
module pc_stack_unit
  import toast_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] SP_RESET    = 16'h8000,
  parameter logic [WIDTH-1:0] STACK_LIMIT = 16'h7FF0,
  parameter logic [WIDTH-1:0] PC_RESET    = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_target,
  input  logic [WIDTH-1:0] op_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] pop_data,
  output logic             done,
  output logic             err,
  output logic             fault_overflow,
  output logic             fault_underflow,
  input  logic             fault_clear
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  pc_state_t        state, state_next;
  op_code_t         op_c, cur_op;
  logic [WIDTH-1:0] wdata_q, target_q;
  logic             accept, is_push, is_pop, overflow, underflow;

  always_comb begin
    op_c       = op_code_t'(op_code);
    op_ready   = (state == ST_IDLE);
    accept     = op_valid && op_ready;
    is_push    = (op_c == OP_PUSH) || (op_c == OP_CALL);
    is_pop     = (op_c == OP_POP) || (op_c == OP_RET);
    overflow   = accept && is_push && (sp == STACK_LIMIT);
    underflow  = accept && is_pop && (sp == SP_RESET);
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_push && !overflow) state_next = ST_WRITE;
        if (accept && is_pop && !underflow) state_next = ST_READ;
      end
      ST_WRITE: state_next = ST_IDLE;
      ST_READ:  if (mem_rvalid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Address/data are forced to zero while idle so the bus is quiet.
    mem_req   = (state != ST_IDLE);
    mem_we    = (state == ST_WRITE);
    mem_addr  = (state == ST_IDLE) ? '0 : sp;
    mem_wdata = (state == ST_WRITE) ? wdata_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      cur_op          <= OP_NOP;
      pc              <= PC_RESET;
      sp              <= SP_RESET;
      pop_data        <= '0;
      wdata_q         <= '0;
      target_q        <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      fault_overflow  <= 1'b0;
      fault_underflow <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      err   <= 1'b0;
      // Clear first so a fault raised in this same cycle overrides it.
      if (fault_clear) begin
        fault_overflow  <= 1'b0;
        fault_underflow <= 1'b0;
      end
      case (state)
        ST_IDLE: if (accept) begin
          cur_op   <= op_c;
          target_q <= op_target;
          case (op_c)
            OP_STEP: begin pc <= pc + ONE; done <= 1'b1; end
            OP_JUMP: begin pc <= op_target; done <= 1'b1; end
            OP_PUSH, OP_CALL: begin
              if (overflow) begin
                fault_overflow <= 1'b1;
                done           <= 1'b1;
                err            <= 1'b1;
              end else begin
                wdata_q <= (op_c == OP_PUSH) ? op_data : pc + ONE;
              end
            end
            OP_POP, OP_RET: begin
              if (underflow) begin
                fault_underflow <= 1'b1;
                done            <= 1'b1;
                err             <= 1'b1;
              end else begin
                sp <= sp + ONE;
              end
            end
            default: done <= 1'b1;
          endcase
        end
        ST_WRITE: begin
          sp   <= sp - ONE;
          done <= 1'b1;
          if (cur_op == OP_CALL) pc <= target_q;
        end
        ST_READ: if (mem_rvalid) begin
          done <= 1'b1;
          if (cur_op == OP_RET) pc <= mem_rdata;
          else pop_data <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: one task per scenario, inline checks
// sampled on the falling edge, summary line at the end.
module tb_pc_stack_unit;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [2:0]   op_code = 3'd0;
  logic [W-1:0] op_target = '0;
  logic [W-1:0] op_data = '0;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic [W-1:0] pc, sp, pop_data;
  logic         done, err, fault_overflow, fault_underflow;
  logic         fault_clear = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] C_NOP = 3'd0, C_STEP = 3'd1, C_JUMP = 3'd2,
                         C_CALL = 3'd3, C_RET = 3'd4, C_PUSH = 3'd5, C_POP = 3'd6;

  pc_stack_unit dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_target(op_target), .op_data(op_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .pc(pc), .sp(sp), .pop_data(pop_data), .done(done), .err(err),
    .fault_overflow(fault_overflow), .fault_underflow(fault_underflow),
    .fault_clear(fault_clear)
  );

  always #5 clock = ~clock;

  // Presents one op for exactly one rising edge; returns at the next falling edge.
  task automatic issue(input logic [2:0] code, input logic [W-1:0] target,
                       input logic [W-1:0] data);
    @(negedge clock);
    op_valid  = 1'b1;
    op_code   = code;
    op_target = target;
    op_data   = data;
    @(negedge clock);
    op_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({pc, sp, pop_data} !== {16'h0000, 16'h8000, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_regs: pc=%h sp=%h pop=%h exp 0000 8000 0000", pc, sp, pop_data);
    end
    vectors++;
    if ({done, err, fault_overflow, fault_underflow, mem_req, mem_we, op_ready} !== 7'b0000001) begin
      miscompares++;
      $display("FAIL reset_flags: d/e/fo/fu/req/we/rdy=%b exp 0000001",
               {done, err, fault_overflow, fault_underflow, mem_req, mem_we, op_ready});
    end
    vectors++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h wdata=%h exp 0000 0000", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      issue(C_STEP, '0, '0);
      if (done === 1'b1 && err === 1'b0) pulses++;
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL step_done_width: done=%b exp 0", done);
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL step_pulses: got %0d exp 3", pulses);
    end
    vectors++;
    if ({pc, sp} !== {16'h0003, 16'h8000}) begin
      miscompares++;
      $display("FAIL step_regs: pc=%h sp=%h exp 0003 8000", pc, sp);
    end
  endtask

  task automatic test_call_ret();
    issue(C_CALL, 16'h0100, 16'hDEAD);
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, done} !== {1'b1, 1'b1, 16'h8000, 16'h0004, 1'b0}) begin
      miscompares++;
      $display("FAIL call_write: req=%b we=%b addr=%h wdata=%h done=%b exp 1 1 8000 0004 0",
               mem_req, mem_we, mem_addr, mem_wdata, done);
    end
    @(negedge clock);
    vectors++;
    if ({done, err, mem_req, sp, pc} !== {1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0100}) begin
      miscompares++;
      $display("FAIL call_done: done=%b err=%b req=%b sp=%h pc=%h exp 1 0 0 7fff 0100",
               done, err, mem_req, sp, pc);
    end
    // Stray rvalid while idle must not disturb anything.
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    @(negedge clock);
    mem_rvalid = 1'b0;
    vectors++;
    if ({done, pc, pop_data} !== {1'b0, 16'h0100, 16'h0000}) begin
      miscompares++;
      $display("FAIL idle_rvalid: done=%b pc=%h pop=%h exp 0 0100 0000", done, pc, pop_data);
    end
    issue(C_RET, '0, '0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({mem_req, mem_we, mem_addr, sp, done} !== {1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0}) begin
        miscompares++;
        $display("FAIL ret_wait%0d: req=%b we=%b addr=%h sp=%h done=%b exp 1 0 8000 8000 0",
                 i, mem_req, mem_we, mem_addr, sp, done);
      end
      if (i < 2) @(negedge clock);
    end
    @(negedge clock);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h0004;
    @(negedge clock);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    vectors++;
    if ({done, err, mem_req, pc, sp} !== {1'b1, 1'b0, 1'b0, 16'h0004, 16'h8000}) begin
      miscompares++;
      $display("FAIL ret_done: done=%b err=%b req=%b pc=%h sp=%h exp 1 0 0 0004 8000",
               done, err, mem_req, pc, sp);
    end
  endtask

  task automatic test_push_overflow();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      issue(C_PUSH, '0, 16'h1000 + 16'(i));
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h8000 - 16'(i) ||
          mem_wdata !== 16'h1000 + 16'(i)) bad++;
      @(negedge clock);
      if (done !== 1'b1 || err !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL push16_bus: %0d bad cycles exp 0", bad);
    end
    vectors++;
    if ({sp, fault_overflow} !== {16'h7FF0, 1'b0}) begin
      miscompares++;
      $display("FAIL push16_sp: sp=%h fo=%b exp 7ff0 0", sp, fault_overflow);
    end
    issue(C_PUSH, '0, 16'hAAAA);
    vectors++;
    if ({mem_req, done, err, fault_overflow, sp} !== {1'b0, 1'b1, 1'b1, 1'b1, 16'h7FF0}) begin
      miscompares++;
      $display("FAIL push_overflow: req=%b done=%b err=%b fo=%b sp=%h exp 0 1 1 1 7ff0",
               mem_req, done, err, fault_overflow, sp);
    end
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    vectors++;
    if (fault_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_clear: fo=%b exp 0", fault_overflow);
    end
    // Refused CALL with a simultaneous clear: the new fault must stick.
    @(negedge clock);
    op_valid = 1'b1; op_code = C_CALL; op_target = 16'h0200; fault_clear = 1'b1;
    @(negedge clock);
    op_valid = 1'b0; fault_clear = 1'b0;
    vectors++;
    if ({fault_overflow, err, pc, sp} !== {1'b1, 1'b1, 16'h0004, 16'h7FF0}) begin
      miscompares++;
      $display("FAIL set_wins: fo=%b err=%b pc=%h sp=%h exp 1 1 0004 7ff0",
               fault_overflow, err, pc, sp);
    end
    issue(C_POP, '0, '0);
    vectors++;
    if ({mem_req, mem_addr, sp} !== {1'b1, 16'h7FF1, 16'h7FF1}) begin
      miscompares++;
      $display("FAIL pop_addr: req=%b addr=%h sp=%h exp 1 7ff1 7ff1", mem_req, mem_addr, sp);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h100F;
    @(negedge clock);
    mem_rvalid = 1'b0;
    vectors++;
    if ({done, pop_data, pc} !== {1'b1, 16'h100F, 16'h0004}) begin
      miscompares++;
      $display("FAIL pop_data: done=%b pop=%h pc=%h exp 1 100f 0004", done, pop_data, pc);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(C_POP, '0, '0);
    vectors++;
    if ({mem_req, done, err, fault_underflow, fault_overflow, sp} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8000}) begin
      miscompares++;
      $display("FAIL underflow: req=%b done=%b err=%b fu=%b fo=%b sp=%h exp 0 1 1 1 0 8000",
               mem_req, done, err, fault_underflow, fault_overflow, sp);
    end
    issue(C_NOP, '0, '0);
    vectors++;
    if ({done, err, fault_underflow, pc} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL nop_sticky: done=%b err=%b fu=%b pc=%h exp 1 0 1 0000",
               done, err, fault_underflow, pc);
    end
  endtask

  task automatic test_pc_wrap();
    issue(C_JUMP, 16'hFFFF, '0);
    vectors++;
    if ({done, pc} !== {1'b1, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL jump: done=%b pc=%h exp 1 ffff", done, pc);
    end
    issue(C_STEP, '0, '0);
    vectors++;
    if ({done, pc} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL pc_wrap: done=%b pc=%h exp 1 0000", done, pc);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    issue(C_PUSH, '0, 16'h5555);
    issue(C_JUMP, 16'h0042, '0);
    issue(C_POP, '0, '0);
    vectors++;
    if ({mem_req, op_ready, sp} !== {1'b1, 1'b0, 16'h8000}) begin
      miscompares++;
      $display("FAIL mid_read_setup: req=%b rdy=%b sp=%h exp 1 0 8000", mem_req, op_ready, sp);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({op_ready, mem_req, done, pc, sp} !== {1'b1, 1'b0, 1'b0, 16'h0000, 16'h8000}) begin
      miscompares++;
      $display("FAIL reset_abort: rdy=%b req=%b done=%b pc=%h sp=%h exp 1 0 0 0000 8000",
               op_ready, mem_req, done, pc, sp);
    end
    @(negedge clock);
    vectors++;
    if ({done, mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_abort_after: done=%b req=%b exp 0 0", done, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_call_ret();
    test_push_overflow();
    test_underflow();
    test_pc_wrap();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
